// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a whole payload from an FWFT byte source,
// then streams header, payload and parity so pkt_valid never drops mid-packet.
module router_pkt_tx #(
  parameter int unsigned LEN_W = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_empty,
  output logic             pl_rd,
  input  logic             busy,
  output logic [7:0]       data_in,
  output logic             pkt_valid,
  output logic             tx_idle,
  output logic             done,
  output logic             start_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StHeader, StPayload, StParity} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       parity_q, parity_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       hdr;
  logic [7:0]       mem_q [DEPTH];

  assign hdr       = {len_q, addr_q};
  assign data_in   = data_q;
  assign pkt_valid = valid_q;
  assign tx_idle   = (state_q == StIdle);
  assign done      = done_q;
  assign start_err = err_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    parity_d = parity_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pl_rd    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (payload_len == '0 || dest_addr == 2'd3) begin
            err_d = 1'b1;
          end else begin
            len_d    = payload_len;
            addr_d   = dest_addr;
            parity_d = {payload_len, dest_addr};
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (!pl_empty) begin
          pl_rd    = 1'b1;
          parity_d = parity_q ^ pl_data;
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          // Header goes out on the same edge the last payload byte is buffered.
          if (wr_cnt_q == len_q - LEN_W'(1)) begin
            data_d  = hdr;
            valid_d = 1'b1;
            state_d = StHeader;
          end
        end
      end
      StHeader: begin
        if (!busy) begin
          data_d   = mem_q[rd_cnt_q];
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
          state_d  = StPayload;
        end
      end
      StPayload: begin
        if (!busy) begin
          // rd_cnt counts bytes already put on data_in; len means the last one was just taken.
          if (rd_cnt_q == len_q) begin
            data_d  = parity_q;
            valid_d = 1'b0;
            state_d = StParity;
          end else begin
            data_d   = mem_q[rd_cnt_q];
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
          end
        end
      end
      StParity: begin
        if (!busy) begin
          done_d  = 1'b1;
          data_d  = 8'h00;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      addr_q   <= '0;
      parity_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      parity_q <= parity_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (pl_rd) begin
      mem_q[wr_cnt_q] <= pl_data;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: FWFT source model, busy driver and byte-stream checker.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] pl_data;
  logic       pl_empty;
  logic       pl_rd;
  logic       busy;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       tx_idle;
  logic       done;
  logic       start_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] src_mem [1024];
  int         src_wr = 0;
  int         src_rd = 0;
  logic       src_hold;
  logic [7:0] pl_exp [64];

  router_pkt_tx #(.LEN_W(6), .DEPTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_empty    (pl_empty),
    .pl_rd       (pl_rd),
    .busy        (busy),
    .data_in     (data_in),
    .pkt_valid   (pkt_valid),
    .tx_idle     (tx_idle),
    .done        (done),
    .start_err   (start_err)
  );

  always #5 clk = ~clk;

  assign pl_data  = src_mem[src_rd % 1024];
  assign pl_empty = src_hold || (src_rd == src_wr);

  always @(posedge clk) begin
    if (pl_rd) src_rd <= src_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    src_mem[src_wr % 1024] = b;
    src_wr++;
  endtask

  // Sends one packet of pl_exp[0..len-1]; exp_lat/exp_pv <= 0 skip those checks.
  task automatic send(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] exp_par,
                      input int exp_lat, input int exp_pv, input int stall_n,
                      input logic [7:0] stall_byte, input int hold_n, input bit rnd_busy,
                      input bit mid_start);
    int         n = 0, lat = 0, pv_cyc = 0, stall_left = stall_n, held = 0, err_seen = 0;
    bit         par_chk = 0, par_seen = 0, fin = 0, b;
    logic [7:0] got [65];
    for (int i = 0; i < int'(len); i++) push(pl_exp[i]);
    @(negedge clk);
    start = 1'b1; dest_addr = addr; payload_len = len; busy = 1'b0;
    for (int k = 1; k <= 3000 && !fin; k++) begin
      @(negedge clk);
      start    = mid_start && (k == 20);
      src_hold = (k <= hold_n);
      if (start_err) err_seen++;
      if (par_seen) begin
        chk("done_pulse", done, 1'b1);
        chk("data_after_parity", data_in, 8'h00);
        chk("idle_after_parity", tx_idle, 1'b1);
        fin = 1;
      end else begin
        b = 1'b0;
        if (rnd_busy) b = ($urandom_range(0, 1) != 0);
        else if (stall_left > 0 && pkt_valid && data_in == stall_byte) begin
          b = 1'b1;
          stall_left--;
        end
        busy = b;
        if (pkt_valid) begin
          if (lat == 0) lat = k;
          pv_cyc++;
          if (stall_n > 0 && data_in == stall_byte) held++;
          if (!b) begin
            if (n < 65) got[n] = data_in;
            n++;
          end
        end else if (lat != 0) begin
          if (!par_chk) begin
            chk("parity", data_in, exp_par);
            par_chk = 1;
          end
          if (!b) par_seen = 1;
        end
      end
    end
    busy = 1'b0;
    src_hold = 1'b0;
    chk("finished", fin, 1'b1);
    chk("byte_count", n, int'(len) + 1);
    chk("header", got[0], {len, addr});
    for (int i = 0; i < int'(len); i++) chk($sformatf("byte%0d", i), got[i+1], pl_exp[i]);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    if (exp_pv > 0) chk("pv_cycles", pv_cyc, exp_pv);
    if (stall_n > 0) chk("stall_hold", held, stall_n + 1);
    chk("no_start_err", err_seen, 0);
    @(negedge clk);
    chk("done_single", done, 1'b0);
    chk("idle_after", tx_idle, 1'b1);
    chk("pv_after", pkt_valid, 1'b0);
  endtask

  task automatic illegal(input logic [1:0] addr, input logic [5:0] len);
    @(negedge clk);
    start = 1'b1; dest_addr = addr; payload_len = len;
    @(negedge clk);
    start = 1'b0;
    chk("start_err_pulse", start_err, 1'b1);
    chk("illegal_idle", tx_idle, 1'b1);
    chk("illegal_no_done", done, 1'b0);
    @(negedge clk);
    chk("start_err_clear", start_err, 1'b0);
    chk("illegal_idle2", tx_idle, 1'b1);
  endtask

  initial begin
    logic [7:0] p;
    reset = 1'b0; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    busy = 1'b0; src_hold = 1'b0;
    #1;
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_start_err", start_err, 1'b0);
    chk("rst_tx_idle", tx_idle, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Basic packet: 0D, A5, 3C, FF then parity 6B
    pl_exp[0] = 8'hA5; pl_exp[1] = 8'h3C; pl_exp[2] = 8'hFF;
    send(2'd1, 6'd3, 8'h6B, 4, 4, 0, 8'h00, 0, 1'b0, 1'b0);
    // Busy stall on 3C for three cycles
    send(2'd1, 6'd3, 8'h6B, 4, 7, 3, 8'h3C, 0, 1'b0, 1'b0);
    // Source underflow: five empty cycles during LOAD
    send(2'd1, 6'd3, 8'h6B, 9, 4, 0, 8'h00, 5, 1'b0, 1'b0);

    illegal(2'd2, 6'd0);
    illegal(2'd3, 6'd5);

    // Reset asserted mid-PAYLOAD
    for (int i = 0; i < 5; i++) push(8'h11 * (i + 1));
    @(negedge clk);
    start = 1'b1; dest_addr = 2'd0; payload_len = 6'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !pkt_valid; k++) @(negedge clk);
    chk("abort_reached", pkt_valid, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_pkt_valid", pkt_valid, 1'b0);
    chk("abort_data_in", data_in, 8'h00);
    chk("abort_tx_idle", tx_idle, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    send(2'd1, 6'd3, 8'h6B, 4, 4, 0, 8'h00, 0, 1'b0, 1'b0);

    // Max length, random data and busy, start pulsed mid-packet
    p = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pl_exp[i] = 8'($urandom_range(0, 255));
      p = p ^ pl_exp[i];
    end
    send(2'd2, 6'd63, p, 64, 0, 0, 8'h00, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
